vram_port_b_sched: RTL

//  Scheduler for port B of the 1 KB video RAM (64x16 text screen, dual-port BRAM).

---
 rtl/vram_port_b_sched_if.sv | 62 ++++++
 rtl/vram_port_b_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vram_port_b_sched_if.sv
// Signal bundle between the VRAM port-B scheduler and its clients.
// The slave side is the scheduler. The master side is the display, host, clear control and the BRAM.
interface vram_port_b_sched_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   // Handshakes:
   //  - disp_req and clr_start are single-cycle pulses that are always accepted.
   //  - host_req is held, with host_we/addr/wdata stable, until the cycle host_gnt=1.
   //    That cycle is the one in which the access is issued.
   //  - *_rvalid are single-cycle pulses with no backpressure.
   //  - *_rdata hold their last value between pulses.
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic              clr_start;
   logic              clr_busy;
   logic              clr_done;

   logic              vram_ce;
   logic              vram_oce;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [DATA_W-1:0] vram_din;
   logic [DATA_W-1:0] vram_dout;

   logic              dbg_clearing;

   modport slave (
      input  disp_req, disp_addr,
      output disp_rvalid, disp_rdata,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      input  clr_start,
      output clr_busy, clr_done,
      output vram_ce, vram_oce, vram_we, vram_addr, vram_din,
      input  vram_dout,
      output dbg_clearing
   );

   modport master (
      output disp_req, disp_addr,
      input  disp_rvalid, disp_rdata,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      output clr_start,
      input  clr_busy, clr_done,
      input  vram_ce, vram_oce, vram_we, vram_addr, vram_din,
      output vram_dout,
      input  dbg_clearing
   );
endinterface

// File: rtl/vram_port_b_sched.sv
// Shares VRAM port B between display fetch, screen-clear engine and host access.
// Returned read data is routed back to its requester through a latency-matched tag pipe.
module vram_port_b_sched #(
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 8,
   parameter int                RD_LAT    = 2,
   parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
   input  logic               clk,
   input  logic               rst_n,
   vram_port_b_sched_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_HOST = 2'd2
   } tag_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   tag_t              tag_q [RD_LAT];
   tag_t              tag_d [RD_LAT];
   logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

   logic gnt_disp, gnt_clr, gnt_host;
   logic disp_hit, host_hit;
   tag_t issue_tag;

   // Grants are gated by rst_n so an asserted reset silences the port within the same cycle.
   always_comb begin : grant
      gnt_disp = rst_n & bus.disp_req;
      gnt_clr  = rst_n & (state_q == ST_CLEAR) & ~bus.disp_req;
      gnt_host = rst_n & (state_q == ST_IDLE) & bus.host_req & ~bus.disp_req;
   end

   always_comb begin : bram_drive
      bus.vram_ce   = gnt_disp | gnt_clr | gnt_host;
      bus.vram_we   = gnt_clr | (gnt_host & bus.host_we);
      bus.vram_addr = '0;
      bus.vram_din  = '0;
      if (gnt_disp) begin
         bus.vram_addr = bus.disp_addr;
      end else if (gnt_clr) begin
         bus.vram_addr = cnt_q;
         bus.vram_din  = FILL_CHAR;
      end else if (gnt_host) begin
         bus.vram_addr = bus.host_addr;
         if (bus.host_we) begin
            bus.vram_din = bus.host_wdata;
         end
      end
   end

   assign bus.vram_oce = 1'b1;
   assign bus.host_gnt = gnt_host;

   always_comb begin : tag_pipe
      issue_tag = TAG_NONE;
      if (gnt_disp) begin
         issue_tag = TAG_DISP;
      end else if (gnt_host && !bus.host_we) begin
         issue_tag = TAG_HOST;
      end
      tag_d[0] = issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // The oldest tag lines up with the BRAM output register for the same read.
   always_comb begin : read_return
      disp_hit     = (tag_q[RD_LAT-1] == TAG_DISP);
      host_hit     = (tag_q[RD_LAT-1] == TAG_HOST);
      disp_rdata_d = disp_hit ? bus.vram_dout : disp_rdata_q;
      host_rdata_d = host_hit ? bus.vram_dout : host_rdata_q;
   end

   assign bus.disp_rvalid = disp_hit;
   assign bus.disp_rdata  = disp_rdata_d;
   assign bus.host_rvalid = host_hit;
   assign bus.host_rdata  = host_rdata_d;

   always_comb begin : clear_fsm
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.clr_start) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            // A display read steals the slot; the counter simply waits for the next free cycle.
            if (gnt_clr) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         disp_rdata_q <= '0;
         host_rdata_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= TAG_NONE;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         disp_rdata_q <= disp_rdata_d;
         host_rdata_q <= host_rdata_d;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign bus.clr_busy     = busy_q;
   assign bus.clr_done     = done_q;
   assign bus.dbg_clearing = (state_q == ST_CLEAR);

`ifndef SYNTHESIS
   a_one_op: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({gnt_disp, gnt_clr, gnt_host}));
   a_no_host_in_clear: assert property (@(posedge clk) disable iff (!rst_n)
      busy_q |-> !gnt_host);
   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      done_q |=> !done_q);
`endif
endmodule
